// File: rtl/wb_load_unit.sv
// Writeback stage: forwards ALU results and waits on the data memory for loads.
// Loaded words are aligned into byte-enabled register-file writes.
module wb_load_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic [3:0]  m_wreg,
   input  logic [4:0]  m_wraddr,
   input  logic [31:0] m_alures,
   input  logic        m_load,
   input  logic [2:0]  m_ltype,
   input  logic [1:0]  m_aoff,
   output logic        m_ready,
   input  logic        d_rvalid,
   input  logic [31:0] d_rdata,
   input  logic        flush,
   output logic [3:0]  we,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        wb_busy,
   output logic        bus_err
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // The counter holds the number of silent WAIT cycles already elapsed.
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [4:0]  ld_addr;
   logic [2:0]  ld_type;
   logic [1:0]  ld_off;

   logic [31:0] sh_r;
   logic [31:0] sh_l;
   logic [15:0] half;
   logic [3:0]  al_we;
   logic [31:0] al_data;

   // Valid/ready: MEM hands over an instruction on a cycle where
   // m_valid & m_ready & !flush; m_ready is high exactly in IDLE.
   assign m_ready = (state == IDLE);
   assign wb_busy = (state == WAIT);

   always_comb begin
      sh_r    = d_rdata >> {ld_off, 3'b000};
      sh_l    = d_rdata << {~ld_off, 3'b000};
      half    = ld_off[1] ? d_rdata[31:16] : d_rdata[15:0];
      al_we   = 4'b1111;
      al_data = d_rdata;
      case (ld_type)
         3'd0: al_data = {{24{sh_r[7]}}, sh_r[7:0]};
         3'd1: al_data = {24'h0, sh_r[7:0]};
         3'd2: al_data = {{16{half[15]}}, half};
         3'd3: al_data = {16'h0, half};
         3'd5: begin
            al_data = sh_l;
            al_we   = 4'b1111 << ~ld_off;
         end
         3'd6: begin
            al_data = sh_r;
            al_we   = 4'b1111 >> ld_off;
         end
         default: begin
            al_data = d_rdata;
            al_we   = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ld_addr <= '0;
         ld_type <= '0;
         ld_off  <= '0;
         we      <= '0;
         waddr   <= '0;
         wdata   <= '0;
         bus_err <= 1'b0;
      end else begin
         we      <= '0;
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (m_valid && !flush) begin
                  if (m_load) begin
                     ld_addr <= m_wraddr;
                     ld_type <= m_ltype;
                     ld_off  <= m_aoff;
                     cnt     <= '0;
                     state   <= WAIT;
                  end else begin
                     we    <= m_wreg;
                     waddr <= m_wraddr;
                     wdata <= m_alures;
                  end
               end
            end
            WAIT: begin
               // Priority: flush, then response, then timeout.
               if (flush) begin
                  state <= IDLE;
               end else if (d_rvalid) begin
                  we    <= al_we;
                  waddr <= ld_addr;
                  wdata <= al_data;
                  state <= IDLE;
               end else if (cnt == LAST_WAIT) begin
                  bus_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
